bayer_stream_gen: RTL and testbench
===================================

Name: bayer_stream_gen

Overview:
- Synthetic camera-side source for the image-processing pipeline.
- Emits a raw Bayer pixel stream (data plus valid plus X/Y counts) with the same line and frame timing the capture front-end produces.
- Bench-free bring-up: drives greyscale/convolution directly with known patterns, with no sensor attached.
- Transmit end of the pixel-stream interface that the processing pipeline receives.

Parameters:
- H_ACTIVE, 1280: active pixels per line (1..2048).
- V_ACTIVE, 960: active lines per frame (1..2048).
- H_BLANK, 16: idle cycles after each active line (>=1).
- V_BLANK, 4: blank lines after the last active line (>=1). Each blank line is H_ACTIVE+H_BLANK cycles.
- DATA_W, 12: pixel width.

Ports:
- iCLK  in  1  clock.
- iRST  in  1  asynchronous, active-high reset.
- iSTART  in  1  start pulse; honoured only in IDLE.
- iSTOP  in  1  stop request; latched, takes effect at end of frame.
- iMODE  in  2  pattern select: 0 const, 1 h-ramp, 2 v-ramp, 3 Bayer checker.
- iCONST  in  DATA_W  constant pixel value for mode 0.
- oX_Cont  out  11  column of the current pixel.
- oY_Cont  out  11  row of the current pixel.
- oDATA  out  DATA_W  pixel value.
- oDVAL  out  1  pixel valid.
- oLVAL  out  1  high for the H_ACTIVE cycles of an active line.
- oFVAL  out  1  high from the first pixel of a frame through the end of the last active line's H_BLANK.
- oFrame_Cnt  out  16  completed frames; wraps 16'hFFFF->0.
- oBUSY  out  1  state != IDLE.

Behaviour:
- All outputs are registered.
- Reset (async, immediate, including mid-frame):
  - state IDLE; all outputs 0.
  - stop latch cleared; frame count 0.
  - A new iSTART is required after reset.
- FSM states: IDLE, ACTIVE, HBLANK, VBLANK.
- IDLE:
  - iSTART=1 -> ACTIVE next cycle with x=0, y=0.
  - Mode is captured from iMODE at this edge.
  - Current iSTOP is discarded on this edge.
- ACTIVE:
  - oDVAL=oLVAL=oFVAL=1.
  - oX_Cont=x, oY_Cont=y, oDATA=pattern(x,y).
  - x increments each cycle.
  - At x==H_ACTIVE-1 -> HBLANK, with the blank counter loaded to H_BLANK.
- HBLANK:
  - oDVAL=oLVAL=0, oFVAL=1, oDATA=0.
  - X/Y hold their last values.
  - After H_BLANK cycles:
    - if y<V_ACTIVE-1: y++, x=0, -> ACTIVE;
    - else -> VBLANK.
- VBLANK:
  - oFVAL=oDVAL=oLVAL=0, oDATA=0.
  - Lasts V_BLANK*(H_ACTIVE+H_BLANK) cycles.
  - oFrame_Cnt increments on the first VBLANK cycle.
  - At the end of VBLANK:
    - if stop latched: -> IDLE, clear latch;
    - else: -> ACTIVE, x=y=0, re-capture iMODE.
- iSTOP:
  - Sets the latch in any non-IDLE state. The current frame always completes.
  - A latch set during VBLANK applies at the end of that VBLANK.
  - iSTART in a non-IDLE state is ignored.
  - iSTART and iSTOP together in IDLE: start wins; the stop is not latched.
- Frame period: (V_ACTIVE+V_BLANK)*(H_ACTIVE+H_BLANK) cycles, back to back.
- Patterns (widths):
  - mode 0: oDATA=iCONST, sampled every pixel.
  - mode 1: oDATA = x zero-extended to DATA_W (truncated if DATA_W<11).
  - mode 2: oDATA = y zero-extended to DATA_W (truncated if DATA_W<11).
  - mode 3: Bayer site {y[0],x[0]}: 00 G -> mid-scale (1<<(DATA_W-1)); 01 R -> all ones; 10 B -> 0; 11 G -> mid-scale.
- Counters x and y are 11 bits. H_ACTIVE=2048 uses the full x range with no overflow, since the compare is done before the increment.

Optional Feature:
- Macro: BAYER_GEN_NOISE_EN.
- Defined:
  - 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset.
  - LFSR advances only on oDVAL cycles.
  - Its low 4 bits XOR into oDATA[3:0] in every mode.
- Undefined: no LFSR logic; oDATA is exactly the pattern.

Decomposition:
- Package bayer_gen_pkg:
  - state enum (IDLE, ACTIVE, HBLANK, VBLANK);
  - mode enum (MODE_CONST, MODE_HRAMP, MODE_VRAMP, MODE_CHECK);
  - LFSR seed and tap constants.
- One sub-module: bayer_pattern_lut, a combinational (mode, x, y, const) -> pixel function, reused by the verification scoreboard.

Test Plan:
Parameters for all scenarios: H_ACTIVE=4, V_ACTIVE=2, H_BLANK=2, V_BLANK=1; frame = 18 cycles.
- Mode 1 with iSTART, iSTOP asserted at the start -> oDATA 0,1,2,3 on row 0 and 0,1,2,3 on row 1; each row followed by 2 oDVAL=0 cycles; 6 VBLANK cycles; oFrame_Cnt=1; oBUSY falls at cycle 18.
- Mode 3, free-running -> row0 = 800,FFF,800,FFF; row1 = 000,800,000,800; oFrame_Cnt increments every 18 cycles; mode changed mid-frame takes effect only at the next frame.
- Mode 0, iCONST=12'h5A5, iSTOP pulsed mid-row1 -> frame completes (8 valid pixels of 5A5), then IDLE; iSTART during the frame is ignored.
- iRST asserted mid-row0 -> all outputs 0 asynchronously (before the next edge); after release, oBUSY stays 0 until iSTART.
- Simultaneous iSTART+iSTOP in IDLE -> runs continuously (at least 3 frames, oFrame_Cnt=3).
- With BAYER_GEN_NOISE_EN, mode 0, iCONST=0 -> oDATA[11:4]=0; oDATA[3:0] matches the LFSR model seeded ACE1.

Source files
------------

// File: rtl/bayer_gen_pkg.sv
// -----------------------------------------------------------------------------
// bayer_gen_pkg
// Shared types and constants for the synthetic Bayer stream generator.
//   state_e : generator FSM states
//   mode_e  : test-pattern selector values (matches the iMODE encoding)
//   LFSR_*  : seed and Galois tap mask of the optional pixel-noise LFSR
//             (used only when BAYER_GEN_NOISE_EN is defined)
// -----------------------------------------------------------------------------
package bayer_gen_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      HBLANK = 2'd2,
      VBLANK = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      MODE_CONST = 2'd0,
      MODE_HRAMP = 2'd1,
      MODE_VRAMP = 2'd2,
      MODE_CHECK = 2'd3
   } mode_e;

   // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form.
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

endpackage

// File: rtl/bayer_pattern_lut.sv
// -----------------------------------------------------------------------------
// bayer_pattern_lut
// Combinational test-pattern function: (mode, x, y, const) -> pixel.
//   mode_i  : pattern select (mode_e)
//   x_i/y_i : 11-bit pixel coordinates
//   const_i : value emitted in MODE_CONST
//   pix_o   : pixel value, DATA_W bits (DATA_W >= 2)
// -----------------------------------------------------------------------------
module bayer_pattern_lut
   import bayer_gen_pkg::*;
#(
   parameter int DATA_W = 12
) (
   input  mode_e             mode_i,
   input  logic [10:0]       x_i,
   input  logic [10:0]       y_i,
   input  logic [DATA_W-1:0] const_i,
   output logic [DATA_W-1:0] pix_o
);

   localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

   // NOTE: every output of a combinational block gets a default first so no
   // path through the case statement can leave it unassigned (a latch).
   always_comb begin
      pix_o = '0;
      case (mode_i)
         MODE_CONST: pix_o = const_i;
         MODE_HRAMP: pix_o = DATA_W'(x_i);
         MODE_VRAMP: pix_o = DATA_W'(y_i);
         default: begin
            // Bayer site {row parity, column parity}: G R / B G.
            case ({y_i[0], x_i[0]})
               2'b01:   pix_o = '1;
               2'b10:   pix_o = '0;
               default: pix_o = MID;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/bayer_stream_gen.sv
// -----------------------------------------------------------------------------
// bayer_stream_gen
// Synthetic raw-Bayer pixel source with capture-front-end line/frame timing.
//   iCLK, iRST     : clock, asynchronous active-high reset
//   iSTART         : start pulse, honoured only while idle
//   iSTOP          : stop request, latched, honoured at end of frame
//   iMODE, iCONST  : pattern select (captured per frame) and constant value
//   oX_Cont/oY_Cont: pixel column / row
//   oDATA, oDVAL   : pixel value and valid
//   oLVAL, oFVAL   : line valid, frame valid
//   oFrame_Cnt     : completed frames (wraps)
//   oBUSY          : generator not idle
// Optional: define BAYER_GEN_NOISE_EN to XOR a 16-bit LFSR's low nibble into
// every valid pixel.
// -----------------------------------------------------------------------------
module bayer_stream_gen
   import bayer_gen_pkg::*;
#(
   parameter int H_ACTIVE = 1280,
   parameter int V_ACTIVE = 960,
   parameter int H_BLANK  = 16,
   parameter int V_BLANK  = 4,
   parameter int DATA_W   = 12
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iSTART,
   input  logic              iSTOP,
   input  logic [1:0]        iMODE,
   input  logic [DATA_W-1:0] iCONST,
   output logic [10:0]       oX_Cont,
   output logic [10:0]       oY_Cont,
   output logic [DATA_W-1:0] oDATA,
   output logic              oDVAL,
   output logic              oLVAL,
   output logic              oFVAL,
   output logic [15:0]       oFrame_Cnt,
   output logic              oBUSY
);

   localparam int LINE_CYC = H_ACTIVE + H_BLANK;
   localparam int VB_CYC   = V_BLANK * LINE_CYC;
   localparam int CNT_W    = $clog2(VB_CYC + 1);

   localparam logic [10:0]      X_LAST   = 11'(H_ACTIVE - 1);
   localparam logic [10:0]      Y_LAST   = 11'(V_ACTIVE - 1);
   localparam logic [CNT_W-1:0] HB_LOAD  = CNT_W'(H_BLANK);
   localparam logic [CNT_W-1:0] VB_LOAD  = CNT_W'(VB_CYC);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e            state_q, state_d;
   mode_e             mode_q, mode_d;
   logic [10:0]       x_q, x_d, y_q, y_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              stop_q, stop_d;
   logic              frame_inc;
   logic [DATA_W-1:0] pix, pix_out;

   // Next-state logic. The blank counter is loaded with the blank length and
   // the phase ends on the cycle it reads one, giving exactly that many cycles.
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      x_d       = x_q;
      y_d       = y_q;
      cnt_d     = cnt_q;
      stop_d    = stop_q;
      frame_inc = 1'b0;
      case (state_q)
         IDLE: begin
            // A stop arriving with the start is deliberately not latched.
            if (iSTART) begin
               state_d = ACTIVE;
               x_d     = '0;
               y_d     = '0;
               mode_d  = mode_e'(iMODE);
            end
         end
         ACTIVE: begin
            stop_d = stop_q | iSTOP;
            // Compare before increment so H_ACTIVE = 2048 never wraps x.
            if (x_q == X_LAST) begin
               state_d = HBLANK;
               cnt_d   = HB_LOAD;
            end else begin
               x_d = x_q + 11'd1;
            end
         end
         HBLANK: begin
            stop_d = stop_q | iSTOP;
            if (cnt_q == CNT_ONE) begin
               if (y_q == Y_LAST) begin
                  state_d   = VBLANK;
                  cnt_d     = VB_LOAD;
                  frame_inc = 1'b1;
               end else begin
                  state_d = ACTIVE;
                  x_d     = '0;
                  y_d     = y_q + 11'd1;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin // VBLANK
            if (cnt_q == CNT_ONE) begin
               if (stop_q | iSTOP) begin
                  state_d = IDLE;
                  stop_d  = 1'b0;
               end else begin
                  state_d = ACTIVE;
                  x_d     = '0;
                  y_d     = '0;
                  mode_d  = mode_e'(iMODE);
               end
            end else begin
               cnt_d  = cnt_q - CNT_ONE;
               stop_d = stop_q | iSTOP;
            end
         end
      endcase
   end

   // Pattern is evaluated on next-state coordinates so oDATA lines up with
   // the registered X/Y of the same cycle.
   bayer_pattern_lut #(.DATA_W(DATA_W)) u_lut (
      .mode_i (mode_d),
      .x_i    (x_d),
      .y_i    (y_d),
      .const_i(iCONST),
      .pix_o  (pix)
   );

`ifdef BAYER_GEN_NOISE_EN
   logic [15:0] lfsr_q;

   // Steps once per emitted pixel, after its low nibble has been used.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST)                  lfsr_q <= LFSR_SEED;
      else if (state_d == ACTIVE) lfsr_q <= lfsr_step(lfsr_q);
   end

   assign pix_out = pix ^ {{(DATA_W-4){1'b0}}, lfsr_q[3:0]};
`else
   assign pix_out = pix;
`endif

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q    <= IDLE;
         mode_q     <= MODE_CONST;
         x_q        <= '0;
         y_q        <= '0;
         cnt_q      <= '0;
         stop_q     <= 1'b0;
         oX_Cont    <= '0;
         oY_Cont    <= '0;
         oDATA      <= '0;
         oDVAL      <= 1'b0;
         oLVAL      <= 1'b0;
         oFVAL      <= 1'b0;
         oFrame_Cnt <= '0;
         oBUSY      <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         x_q        <= x_d;
         y_q        <= y_d;
         cnt_q      <= cnt_d;
         stop_q     <= stop_d;
         oX_Cont    <= x_d;
         oY_Cont    <= y_d;
         oDATA      <= (state_d == ACTIVE) ? pix_out : '0;
         oDVAL      <= (state_d == ACTIVE);
         oLVAL      <= (state_d == ACTIVE);
         oFVAL      <= (state_d == ACTIVE) || (state_d == HBLANK);
         oBUSY      <= (state_d != IDLE);
         if (frame_inc) oFrame_Cnt <= oFrame_Cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_bayer_stream_gen.sv
// -----------------------------------------------------------------------------
// tb_bayer_stream_gen
// Small-geometry bench (4x2 active, 2 h-blank, 1 v-blank line, 18-cycle
// frame). A frame-position model derives every expected output from the
// position within the frame; directed scenarios pin it with literal values.
// -----------------------------------------------------------------------------
module tb_bayer_stream_gen;

   localparam int H_ACTIVE = 4;
   localparam int V_ACTIVE = 2;
   localparam int H_BLANK  = 2;
   localparam int V_BLANK  = 1;
   localparam int DATA_W   = 12;
   localparam int LINE     = H_ACTIVE + H_BLANK;
   localparam int FRAME    = (V_ACTIVE + V_BLANK) * LINE;

   logic              iCLK = 1'b0;
   logic              iRST = 1'b0;
   logic              iSTART = 1'b0;
   logic              iSTOP = 1'b0;
   logic [1:0]        iMODE = 2'd0;
   logic [DATA_W-1:0] iCONST = '0;
   logic [10:0]       oX_Cont, oY_Cont;
   logic [DATA_W-1:0] oDATA;
   logic              oDVAL, oLVAL, oFVAL, oBUSY;
   logic [15:0]       oFrame_Cnt;

   bayer_stream_gen #(
      .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK),
      .V_BLANK(V_BLANK), .DATA_W(DATA_W)
   ) dut (
      .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iSTOP(iSTOP),
      .iMODE(iMODE), .iCONST(iCONST), .oX_Cont(oX_Cont), .oY_Cont(oY_Cont),
      .oDATA(oDATA), .oDVAL(oDVAL), .oLVAL(oLVAL), .oFVAL(oFVAL),
      .oFrame_Cnt(oFrame_Cnt), .oBUSY(oBUSY)
   );

   always #5 iCLK = ~iCLK;

   int n_checks = 0;
   int n_err    = 0;
   bit chk_on   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic [11:0] pat(input int mode, input int x, input int y,
                                       input logic [11:0] c);
      case (mode)
         0: return c;
         1: return 12'(x);
         2: return 12'(y);
         default: begin
            if (x % 2 == 1 && y % 2 == 0) return 12'hFFF;
            else if (x % 2 == 0 && y % 2 == 1) return 12'h000;
            else return 12'h800;
         end
      endcase
   endfunction

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
   endfunction

   bit          m_run = 1'b0;
   bit          m_stop = 1'b0;
   int          m_pos = 0;
   int          m_mode = 0;
   logic [15:0] m_frames = '0;
   logic [15:0] m_lfsr = 16'hACE1;
   bit          e_dval = 1'b0, e_fval = 1'b0;
   int          e_x = 0, e_y = 0;
   logic [11:0] e_data = '0;

   always @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         m_run = 0; m_stop = 0; m_pos = 0; m_frames = '0; m_lfsr = 16'hACE1;
         e_dval = 0; e_fval = 0; e_x = 0; e_y = 0; e_data = '0;
      end else begin
         if (!m_run) begin
            if (iSTART) begin
               m_run = 1; m_pos = 0; m_mode = int'(iMODE); m_stop = 0;
            end
         end else begin
            if (iSTOP) m_stop = 1;
            if (m_pos == FRAME - 1) begin
               if (m_stop) begin
                  m_run = 0; m_stop = 0;
               end else begin
                  m_pos = 0; m_mode = int'(iMODE);
               end
            end else begin
               m_pos++;
               if (m_pos == V_ACTIVE * LINE) m_frames = m_frames + 16'd1;
            end
         end
         e_fval = m_run && (m_pos / LINE) < V_ACTIVE;
         e_dval = e_fval && (m_pos % LINE) < H_ACTIVE;
         e_y    = m_pos / LINE;
         e_x    = e_dval ? (m_pos % LINE) : H_ACTIVE - 1;
         e_data = e_dval ? pat(m_mode, m_pos % LINE, m_pos / LINE, iCONST) : 12'h000;
`ifdef BAYER_GEN_NOISE_EN
         if (e_dval) begin
            e_data[3:0] = e_data[3:0] ^ m_lfsr[3:0];
            m_lfsr = lfsr_next(m_lfsr);
         end
`endif
      end
   end

   // Compare process: every cycle, away from the active edge.
   always @(negedge iCLK) begin
      if (chk_on) begin
         check("busy", 32'(oBUSY), 32'(m_run));
         check("dval", 32'(oDVAL), 32'(e_dval));
         check("lval", 32'(oLVAL), 32'(e_dval));
         check("fval", 32'(oFVAL), 32'(e_fval));
         check("frame_cnt", 32'(oFrame_Cnt), 32'(m_frames));
         check("data", 32'(oDATA), 32'(e_data));
         if (e_fval) begin
            check("x", 32'(oX_Cont), 32'(e_x));
            check("y", 32'(oY_Cont), 32'(e_y));
         end
      end
   end

   // Captures every valid pixel for the literal checks.
   logic [11:0] cap[$];
   always @(negedge iCLK) if (oDVAL) cap.push_back(oDATA);

   // ---------------- stimulus helpers ----------------
   task automatic check_all_zero(input string tag);
      check({tag, "_x"},     32'(oX_Cont), 0);
      check({tag, "_y"},     32'(oY_Cont), 0);
      check({tag, "_data"},  32'(oDATA), 0);
      check({tag, "_dval"},  32'(oDVAL), 0);
      check({tag, "_lval"},  32'(oLVAL), 0);
      check({tag, "_fval"},  32'(oFVAL), 0);
      check({tag, "_frame"}, 32'(oFrame_Cnt), 0);
      check({tag, "_busy"},  32'(oBUSY), 0);
   endtask

   // Leaves the bench at the negedge of the first active cycle (cycle 0).
   task automatic launch(input logic [1:0] mode, input logic [11:0] c, input bit stop);
      @(negedge iCLK);
      cap.delete();
      iMODE = mode; iCONST = c; iSTART = 1'b1; iSTOP = stop;
      @(negedge iCLK);
      iSTART = 1'b0; iSTOP = 1'b0;
   endtask

   // From cycle 0: pulses start/stop at the given cycle indices and counts
   // busy cycles until the generator goes idle (bounded).
   task automatic run_until_idle(input int start_at, input int stop_at, output int busy_n);
      busy_n = 0;
      for (int c = 0; c < 200; c++) begin
         iSTART = (c == start_at);
         iSTOP  = (c == stop_at);
         if (!oBUSY) break;
         busy_n++;
         @(negedge iCLK);
      end
      iSTART = 1'b0; iSTOP = 1'b0;
   endtask

   task automatic random_run(input int n, input bit allow_stop);
      for (int i = 0; i < n; i++) begin
         iMODE  = 2'($urandom);
         iCONST = 12'($urandom);
         iSTART = ($urandom_range(0, 15) == 0);
         iSTOP  = allow_stop && ($urandom_range(0, 40) == 0);
         @(negedge iCLK);
      end
      iSTART = 1'b0; iSTOP = 1'b0;
   endtask

   localparam logic [11:0] S1_EXP [8]  = '{12'h0, 12'h1, 12'h2, 12'h3,
                                           12'h0, 12'h1, 12'h2, 12'h3};
   localparam logic [11:0] S2_EXP [16] = '{12'h800, 12'hFFF, 12'h800, 12'hFFF,
                                           12'h000, 12'h800, 12'h000, 12'h800,
                                           12'h000, 12'h001, 12'h002, 12'h003,
                                           12'h000, 12'h001, 12'h002, 12'h003};

   initial begin
      int n;
      int cnt5a5;

      // Reset state.
      #1 iRST = 1'b1;
      repeat (2) @(negedge iCLK);
      check_all_zero("reset");
      chk_on = 1'b1;
      iRST = 1'b0;
      repeat (2) @(negedge iCLK);

      // 1: h-ramp, single frame (stop held into the first active cycle).
      launch(2'd1, 12'h000, 1'b1);
      run_until_idle(-1, 0, n);
      check("s1_busy_cycles", 32'(n), 18);
      check("s1_frame_cnt", 32'(oFrame_Cnt), 1);
      check("s1_pixels", 32'(cap.size()), 8);
`ifdef BAYER_GEN_NOISE_EN
      if (cap.size() > 0) check("s1_noise_px0", 32'(cap[0]), 32'h001);
`else
      for (int i = 0; i < 8 && i < cap.size(); i++)
         check($sformatf("s1_px%0d", i), 32'(cap[i]), 32'(S1_EXP[i]));
`endif

      // 2: Bayer checker, free-running; mode change mid-frame lands next frame.
      launch(2'd3, 12'h000, 1'b0);
      repeat (8) @(negedge iCLK);
      iMODE = 2'd1;
      for (int i = 0; i < 60 && cap.size() < 16; i++) @(negedge iCLK);
      check("s2_pixels", 32'(cap.size() >= 16), 1);
`ifndef BAYER_GEN_NOISE_EN
      for (int i = 0; i < 16 && i < cap.size(); i++)
         check($sformatf("s2_px%0d", i), 32'(cap[i]), 32'(S2_EXP[i]));
`endif
      random_run(120, 1'b0);
      run_until_idle(-1, 0, n);
      check("s2_stopped", 32'(oBUSY), 0);

      // 3: constant 5A5, stray start ignored, stop mid row 1.
      launch(2'd0, 12'h5A5, 1'b0);
      run_until_idle(3, 7, n);
      check("s3_busy_cycles", 32'(n), 18);
      cnt5a5 = 0;
      foreach (cap[i]) if (cap[i] == 12'h5A5) cnt5a5++;
      check("s3_pixels", 32'(cap.size()), 8);
`ifndef BAYER_GEN_NOISE_EN
      check("s3_5a5_pixels", 32'(cnt5a5), 8);
`endif
      repeat (5) @(negedge iCLK);
      check("s3_stays_idle", 32'(oBUSY), 0);

      // 4: asynchronous reset mid row 0.
      launch(2'd1, 12'h000, 1'b0);
      repeat (2) @(posedge iCLK);
      #3 iRST = 1'b1;
      #1 check_all_zero("async_rst");
      repeat (2) @(negedge iCLK);
      iRST = 1'b0;
      repeat (5) @(negedge iCLK);
      check("s4_idle_after_rst", 32'(oBUSY), 0);

      // 5: start+stop together in idle -> runs continuously.
      launch(2'($urandom), 12'($urandom), 1'b1);
      random_run(53, 1'b0);
      check("s5_frame_cnt", 32'(oFrame_Cnt), 3);
      check("s5_busy", 32'(oBUSY), 1);

      // Random soak with stops and restarts, then drain.
      random_run(400, 1'b1);
      run_until_idle(-1, 0, n);
      check("final_idle", 32'(oBUSY), 0);

      @(negedge iCLK);
      chk_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
